btn_conditioner: RTL

//  Conditions the raw Nexys4 push-buttons (BtnU, BtnD, BtnC, ...) before they reach
//  vga_bitchange. Per button: 2-FF synchronizer, debounce, then a clean level plus
//  one-cycle press/release/auto-repeat pulses. Instantiated in vga_top between the

---
 rtl/pong_pkg.sv | 18 +
 rtl/btn_debounce_lane.sv | 127 ++++++++++++
 rtl/btn_conditioner.sv | 42 ++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the push-button conditioning path: lane state
// encodings and clock-rate helpers for turning milliseconds into cycle counts.
package pong_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } lane_state_e;

  localparam int unsigned CLK_HZ = 100_000_000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return ms * (CLK_HZ / 1000);
  endfunction

endpackage

// File: rtl/btn_debounce_lane.sv
// One button lane: 2-FF synchronizer, debounce FSM, auto-repeat counter and
// registered level / press / release / repeat outputs.
module btn_debounce_lane
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_raw_i,
  output logic        level_o,
  output logic        press_o,
  output logic        release_o,
  output logic        repeat_o,
  output lane_state_e state_o
);

  localparam bit          REPEAT_EN = (REPEAT_DELAY > 0);
  localparam int unsigned DW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RMAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW        = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RLOAD = RW'(REPEAT_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] PLOAD = RW'(REPEAT_PERIOD - 1);

  logic          ff1_q, ff2_q;
  lane_state_e   state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1_q     <= 1'b0;
      ff2_q     <= 1'b0;
      state_q   <= S_LOW;
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      ff1_q     <= btn_raw_i;
      ff2_q     <= ff1_q;
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      rcnt_q    <= rcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  // rcnt counts down to zero: loaded with the initial delay on press and with
  // the period after each repeat, so a single comparator serves both.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    rcnt_d    = rcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      S_LOW: begin
        level_d = 1'b0;
        if (ff2_q) begin
          state_d = S_RISE;
          dcnt_d  = '0;
        end
      end
      S_RISE: begin
        if (!ff2_q) begin
          state_d = S_LOW;
        end else if (dcnt_q == DLAST) begin
          state_d = S_HIGH;
          press_d = 1'b1;
          level_d = 1'b1;
          rcnt_d  = RLOAD;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        level_d = 1'b1;
        if (!ff2_q) begin
          state_d = S_FALL;
          dcnt_d  = '0;
        end else if (REPEAT_EN) begin
          if (rcnt_q == '0) begin
            repeat_d = 1'b1;
            rcnt_d   = PLOAD;
          end else begin
            rcnt_d = rcnt_q - 1'b1;
          end
        end
      end
      S_FALL: begin
        if (ff2_q) begin
          state_d = S_HIGH;
        end else if (dcnt_q == DLAST) begin
          state_d   = S_LOW;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = S_LOW;
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;
  assign state_o   = state_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions NUM_BTN raw push-buttons into debounced levels plus one-cycle
// press / release / auto-repeat pulses; each button is an independent lane.
module btn_conditioner
  import pong_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BTN-1:0]   btn_raw,
  output logic [NUM_BTN-1:0]   btn_level,
  output logic [NUM_BTN-1:0]   btn_press,
  output logic [NUM_BTN-1:0]   btn_release,
  output logic [NUM_BTN-1:0]   btn_repeat,
  output logic [2*NUM_BTN-1:0] btn_state_dbg
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    lane_state_e lane_state;

    btn_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .btn_raw_i(btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .repeat_o (btn_repeat[i]),
      .state_o  (lane_state)
    );

    assign btn_state_dbg[2*i +: 2] = lane_state;
  end

endmodule
